// File: rtl/rca_nibble_sequencer_pkg.sv
// rtl/rca_nibble_sequencer_pkg.sv - shared types and constants for the nibble-serial add/sub sequencer
package rca_nibble_sequencer_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_nibble_sequencer_if.sv
// rtl/rca_nibble_sequencer_if.sv - requester-side start/ready/done bus of the nibble sequencer
interface rca_nibble_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b,
    input  ready, busy, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b,
    output ready, busy, done, result, cout, ovf
  );

endinterface

// File: rtl/rc_adder.sv
// rtl/rc_adder.sv - shared 4-bit ripple-carry adder datapath
module rc_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/rca_nibble_sequencer.sv
// rtl/rca_nibble_sequencer.sv - multi-precision add/sub over an external 4-bit adder, LSB nibble first
module rca_nibble_sequencer
  import rca_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_nibble_sequencer_if.slave bus,
  output logic [NIBBLE_W-1:0]  add_a,
  output logic [NIBBLE_W-1:0]  add_b,
  output logic                 add_cin,
  input  logic [NIBBLE_W-1:0]  add_s,
  input  logic                 add_cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("rca_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Bit offset of the current nibble; shifting avoids a zero-width index when NIB=1.
  logic [IDX_W+1:0] sh;
  logic [WIDTH-1:0] nib_mask;

  assign sh       = {idx_q, 2'b00};
  assign nib_mask = WIDTH'(4'hF) << sh;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.op_a;
          b_d      = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d  = bus.sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        add_a    = NIBBLE_W'(a_q >> sh);
        add_b    = NIBBLE_W'(b_q >> sh);
        add_cin  = carry_q;
        result_d = (result_q & ~nib_mask) | (WIDTH'(add_s) << sh);
        carry_d  = add_cout;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_s[NIBBLE_W-1] != a_q[WIDTH-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready  = (state_q == ST_IDLE);
  assign bus.busy   = (state_q == ST_RUN);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// tb/tb_rca_nibble_sequencer.sv - directed self-checking bench for rca_nibble_sequencer (WIDTH 16 and 4)
module tb_rca_nibble_sequencer;

  logic clk;
  logic rst_n;

  rca_nibble_sequencer_if #(.WIDTH(16)) bus16 ();
  rca_nibble_sequencer_if #(.WIDTH(4))  bus4 ();

  logic [3:0] add_a16, add_b16, add_s16;
  logic       add_cin16, add_cout16;
  logic [3:0] add_a4, add_b4, add_s4;
  logic       add_cin4, add_cout4;

  rca_nibble_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave),
    .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
    .add_s(add_s16), .add_cout(add_cout16)
  );

  rc_adder u_add16 (
    .a(add_a16), .b(add_b16), .cin(add_cin16), .s(add_s16), .cout(add_cout16)
  );

  rca_nibble_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_s(add_s4), .add_cout(add_cout4)
  );

  rc_adder u_add4 (
    .a(add_a4), .b(add_b4), .cin(add_cin4), .s(add_s4), .cout(add_cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt16 = 0;

  always @(negedge clk) if (bus16.done) done_cnt16++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits from the cycle after the accepting edge until done; returns edges elapsed and ready-low samples.
  task automatic wait16(output int lat, output int rlow, output logic [3:0] cin_tr);
    lat = 0; rlow = 0; cin_tr = '0;
    while (!bus16.done && lat < 20) begin
      if (!bus16.ready) rlow++;
      if (bus16.busy) cin_tr[lat % 4] = add_cin16;
      step();
      lat++;
    end
    if (!bus16.ready) rlow++;
  endtask

  task automatic run16(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp_r, input logic exp_c, input logic exp_v,
                       output logic [3:0] cin_tr);
    int lat, rlow;
    bus16.start = 1'b1; bus16.sub = s; bus16.op_a = a; bus16.op_b = b;
    step();
    bus16.start = 1'b0; bus16.sub = ~s; bus16.op_a = ~a; bus16.op_b = ~b;
    wait16(lat, rlow, cin_tr);
    check({tag, " latency"}, lat, 4);
    check({tag, " result"}, bus16.result, exp_r);
    check({tag, " cout"}, bus16.cout, exp_c);
    check({tag, " ovf"}, bus16.ovf, exp_v);
    step();
    check({tag, " ready_low"}, rlow, 5);
    check({tag, " ready_after"}, bus16.ready, 1'b1);
    check({tag, " done_1cyc"}, bus16.done, 1'b0);
  endtask

  initial begin
    logic [3:0] tr;
    int lat, rlow, dc;

    rst_n = 1'b0;
    bus16.start = 0; bus16.sub = 0; bus16.op_a = '0; bus16.op_b = '0;
    bus4.start = 0;  bus4.sub = 0;  bus4.op_a = '0;  bus4.op_b = '0;
    step(); step();
    check("rst ready", bus16.ready, 1'b1);
    check("rst busy", bus16.busy, 1'b0);
    check("rst done", bus16.done, 1'b0);
    check("rst result", bus16.result, 16'h0);
    check("rst cout_ovf", {bus16.cout, bus16.ovf}, 2'b00);
    check("rst add_port", {add_a16, add_b16, add_cin16}, 9'h0);
    check("rst ready4", bus4.ready, 1'b1);
    rst_n = 1'b1;
    step();

    run16("add1234", 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, tr);
    run16("addffff", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, tr);
    check("addffff cin_trace", tr, 4'b1110);
    check("idle add_cin", add_cin16, 1'b0);
    run16("add7fff", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, tr);
    run16("sub5_7", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, tr);
    run16("sub8000_1", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, tr);

    // Starts during RUN (edge 2) and DONE (edge 5) are ignored; held start is taken at edge 6.
    dc = done_cnt16;
    bus16.start = 1'b1; bus16.sub = 0; bus16.op_a = 16'h1111; bus16.op_b = 16'h2222;
    step();
    bus16.start = 1'b0;
    step();
    bus16.start = 1'b1; bus16.op_a = 16'hAAAA; bus16.op_b = 16'h5555;
    step();
    bus16.start = 1'b0;
    step();
    step();
    check("ign done_at4", bus16.done, 1'b1);
    check("ign result", bus16.result, 16'h3333);
    bus16.start = 1'b1;
    step();
    check("ign edge5_ready", bus16.ready, 1'b1);
    check("ign edge5_result", bus16.result, 16'h3333);
    check("ign done_count", done_cnt16 - dc, 1);
    step();
    bus16.start = 1'b0;
    check("ign edge6_busy", bus16.busy, 1'b1);
    wait16(lat, rlow, tr);
    check("ign second_lat", lat, 4);
    check("ign second_result", bus16.result, 16'hFFFF);
    step();

    // Reset during RUN aborts with no done pulse.
    dc = done_cnt16;
    bus16.start = 1'b1; bus16.op_a = 16'h1234; bus16.op_b = 16'h1111;
    step();
    bus16.start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort ready", bus16.ready, 1'b1);
    check("abort busy", bus16.busy, 1'b0);
    check("abort result", bus16.result, 16'h0);
    step(); step(); step(); step();
    check("abort no_done", done_cnt16 - dc, 0);
    run16("post_abort", 1'b0, 16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 1'b0, tr);

    // WIDTH=4 single-nibble instance.
    bus4.start = 1'b1; bus4.sub = 0; bus4.op_a = 4'h9; bus4.op_b = 4'h9;
    step();
    bus4.start = 1'b0; bus4.op_a = 4'h0; bus4.op_b = 4'h0;
    lat = 0;
    while (!bus4.done && lat < 10) begin
      step();
      lat++;
    end
    check("w4 latency", lat, 1);
    check("w4 result", bus4.result, 4'h2);
    check("w4 cout", bus4.cout, 1'b1);
    check("w4 ovf", bus4.ovf, 1'b1);
    step();
    check("w4 ready_after", bus4.ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
